// File: rtl/qspi_flash_pkg.sv
// Shared FSM encodings and protocol constants for the quad-I/O flash read master.
package qspi_flash_pkg;
  typedef logic [3:0] state_t;

  localparam state_t IDLE  = 4'd0;
  localparam state_t MBR   = 4'd1;
  localparam state_t CMD   = 4'd2;
  localparam state_t ADDR  = 4'd3;
  localparam state_t MODE  = 4'd4;
  localparam state_t DUMMY = 4'd5;
  localparam state_t DATA  = 4'd6;
  localparam state_t DONE  = 4'd7;
  localparam state_t CSHI  = 4'd8;

  localparam logic [7:0] CMD_QUAD_RD = 8'hEB;
  localparam logic [7:0] MODE_XIP    = 8'hA5;
  localparam logic [7:0] MODE_NOXIP  = 8'h00;
endpackage

// File: rtl/qspi_flash_sck_gen.sv
// SCK divider: toggles spi_clk every CLK_DIV clocks while enabled, idles low otherwise.
// sck_rise/sck_fall are high in the system cycle whose closing edge moves spi_clk.
module qspi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic spi_clk,
  output logic sck_rise,
  output logic sck_fall
);
  logic [7:0] div_cnt;
  logic       tick;

  assign tick     = en && (div_cnt == 8'(CLK_DIV - 1));
  assign sck_rise = tick && !spi_clk;
  assign sck_fall = tick && spi_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= 8'd0;
      spi_clk <= 1'b0;
    end else if (!en) begin
      div_cnt <= 8'd0;
      spi_clk <= 1'b0;
    end else if (tick) begin
      div_cnt <= 8'd0;
      spi_clk <= ~spi_clk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end
endmodule

// File: rtl/qspi_flash_rd_ctrl.sv
// Quad-I/O (0xEB) 32-bit word read master; one request in flight, ready pulses once per word.
// Define QSPI_XIP_CONT_EN for continuous-read mode (skips CMD, mode-bit-reset burst after reset).
module qspi_flash_rd_ctrl
  import qspi_flash_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int DUMMY_CYCLES = 4,
  parameter int CS_HIGH_MIN  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  output logic        ready,
  input  logic [23:0] addr,
  output logic [31:0] rdata,
  output logic        spi_csb,
  output logic        spi_clk,
  output logic [3:0]  io_out,
  output logic [3:0]  io_oe,
  input  logic [3:0]  io_in
);
`ifdef QSPI_XIP_CONT_EN
  localparam logic [7:0] MODE_BYTE = MODE_XIP;
`else
  localparam logic [7:0] MODE_BYTE = MODE_NOXIP;
`endif

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] tx;
  logic [31:0] rx;
  logic [23:0] addr_q;
  logic [23:0] addr_al;
  logic        xip_active;
  logic        mbr_pend;
  logic        sck_en, sck_rise, sck_fall;

  assign addr_al = addr & 24'hFFFFFC;
  assign sck_en  = (state != IDLE) && (state != CSHI) && (state != DONE);

  qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk      (clk),
    .rst      (rst),
    .en       (sck_en),
    .spi_clk  (spi_clk),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall)
  );

  // Pad drive is decoded from registers that only move on SCK fall or CS assertion.
  always_comb begin
    io_out = 4'b0000;
    io_oe  = 4'b0000;
    case (state)
      CMD, MBR: begin
        io_out = {3'b000, tx[31]};
        io_oe  = 4'b0001;
      end
      ADDR, MODE: begin
        io_out = tx[31:28];
        io_oe  = 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef QSPI_XIP_CONT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xip_active <= 1'b0;
      mbr_pend   <= 1'b1;
    end else begin
      if (state == DONE) xip_active <= 1'b1;
      if (state == MBR && sck_fall && cnt == 8'd7) mbr_pend <= 1'b0;
    end
  end
`else
  assign xip_active = 1'b0;
  assign mbr_pend   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      tx      <= 32'd0;
      rx      <= 32'd0;
      addr_q  <= 24'd0;
      ready   <= 1'b0;
      rdata   <= 32'd0;
      spi_csb <= 1'b1;
    end else begin
      ready <= 1'b0;
      if (sck_rise && state == DATA) rx <= {rx[27:0], io_in};
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (mbr_pend) begin
            state   <= MBR;
            spi_csb <= 1'b0;
            tx      <= 32'hFFFF_FFFF;
          end else if (valid) begin
            addr_q  <= addr_al;
            spi_csb <= 1'b0;
            if (xip_active) begin
              state <= ADDR;
              tx    <= {addr_al, MODE_BYTE};
            end else begin
              state <= CMD;
              tx    <= {CMD_QUAD_RD, 24'h000000};
            end
          end
        end
        MBR: if (sck_fall) begin
          cnt <= cnt + 8'd1;
          tx  <= {tx[30:0], 1'b1};
          if (cnt == 8'd7) begin
            state   <= CSHI;
            cnt     <= 8'd0;
            spi_csb <= 1'b1;
          end
        end
        CMD: if (sck_fall) begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'd7) begin
            state <= ADDR;
            cnt   <= 8'd0;
            tx    <= {addr_q, MODE_BYTE};
          end else begin
            tx <= {tx[30:0], 1'b0};
          end
        end
        // Address nibbles flow straight into the mode byte from the same shifter.
        ADDR, MODE: if (sck_fall) begin
          cnt <= cnt + 8'd1;
          tx  <= {tx[27:0], 4'h0};
          if (state == ADDR && cnt == 8'd5) begin
            state <= MODE;
            cnt   <= 8'd0;
          end else if (state == MODE && cnt == 8'd1) begin
            state <= DUMMY;
            cnt   <= 8'd0;
          end
        end
        DUMMY: if (sck_fall) begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'(DUMMY_CYCLES - 1)) begin
            state <= DATA;
            cnt   <= 8'd0;
          end
        end
        DATA: if (sck_fall) begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'd7) begin
            state   <= DONE;
            cnt     <= 8'd0;
            spi_csb <= 1'b1;
            ready   <= 1'b1;
            rdata   <= {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
          end
        end
        DONE: begin
          state <= CSHI;
          cnt   <= 8'd0;
        end
        CSHI: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'(CS_HIGH_MIN - 1)) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
